// File: rtl/req_priority_encoder_pkg.sv
// Shared defaults and FSM state encoding for the request priority encoder.
// No logic; imported by the encoder top and its selection sub-module.
package req_priority_encoder_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/req_priority_encoder_prio_enc.sv
// Highest-set-index selector: idx is the top set bit of vec, any flags a non-empty vec.
// Purely combinational, zero latency; no backpressure.
module prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the last hit wins, so bit N-1 has top priority.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
        any = |vec;
    end

endmodule

// File: rtl/req_priority_encoder.sv
// Captures falling edges on active-low request lines and offers their indices, highest first.
// Event at edge E0 is pending at E0 and offered at E1; code/valid hold until ready, one idle cycle between offers.
module req_priority_encoder
    import req_priority_encoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_n,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         ovf
);

    logic [N-1:0] prev_q;
    logic [N-1:0] pending_q, pending_d;
    logic         ovf_q, ovf_d;
    logic [N-1:0] ev;
    logic [N-1:0] clr;
    state_t       state_q;
    logic [W-1:0] code_q;
    logic         valid_q;
    logic [W-1:0] sel_idx;
    logic         sel_any;

    prio_enc #(
        .N (N),
        .W (W)
    ) u_prio_enc (
        .vec (pending_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    // A new event on the bit being served survives its own clear; only an
    // event hitting a still-pending bit is a loss.
    always_comb begin
        ev  = prev_q & ~req_n;
        clr = '0;
        if (state_q == OFFER && ready) clr[code_q] = 1'b1;
        pending_d = (pending_q & ~clr) | ev;
        ovf_d     = ovf_q | (|(ev & pending_q & ~clr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '1;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            prev_q    <= req_n;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        state_q <= OFFER;
                        code_q  <= sel_idx;
                        valid_q <= 1'b1;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Bench for req_priority_encoder: vector table, corner sequences and a code scoreboard.
module tb_req_priority_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req_drv;
    logic [7:0] req_n;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       ovf;

    logic       lb_mode;
    logic       dec_en;
    logic [2:0] dec_in;
    logic       lb_ok;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];
    logic       hs_prev;

    typedef struct {
        logic [7:0] mask;
        logic [2:0] exp_first;
    } vec_t;
    vec_t tbl[6];

    assign req_n = lb_mode ? (dec_en ? ~(8'h01 << dec_in) : 8'hff) : req_drv;

    req_priority_encoder #(.N(8), .W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_n   (req_n),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .ovf     (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((sb.size() != 0 || valid || pending != 8'h00) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=<%0d (queue=%0d)", name, n, max, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ovf", 32'(ovf), 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Handshake monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) chk("bubble", 32'(valid), 0);
            hs_prev = valid && ready;
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_offer actual=%0d required=none", code);
                end else begin
                    logic [2:0] e;
                    e = sb.pop_front();
                    lb_ok = (code == e);
                    chk("code", 32'(code), 32'(e));
                end
            end
        end
    end

    initial begin
        tbl[0] = '{8'h01, 3'd0};
        tbl[1] = '{8'h80, 3'd7};
        tbl[2] = '{8'h81, 3'd7};
        tbl[3] = '{8'hff, 3'd7};
        tbl[4] = '{8'h5a, 3'd6};
        tbl[5] = '{8'h24, 3'd5};

        rst = 1'b1; req_drv = 8'hff; ready = 1'b0;
        lb_mode = 1'b0; dec_en = 1'b0; dec_in = 3'd0; lb_ok = 1'b0;
        hs_prev = 1'b0;
        #2;
        chk("init_valid", 32'(valid), 0);
        chk("init_code", 32'(code), 0);
        chk("init_pending", 32'(pending), 0);
        chk("init_ovf", 32'(ovf), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request on bit 5
        ready = 1'b1;
        req_drv[5] = 1'b0;
        sb.push_back(3'd5);
        tick();
        req_drv = 8'hff;
        chk("single_pend_e0", 32'(pending), 32'h20);
        chk("single_valid_e0", 32'(valid), 0);
        tick();
        chk("single_valid_e1", 32'(valid), 1);
        chk("single_code_e1", 32'(code), 5);
        tick();
        chk("single_valid_after", 32'(valid), 0);
        chk("single_pend_after", 32'(pending), 0);
        chk("single_ovf", 32'(ovf), 0);

        // Table: simultaneous events drain highest index first
        for (int t = 0; t < 6; t++) begin
            ready = 1'b1;
            req_drv = ~tbl[t].mask;
            for (int b = 7; b >= 0; b--) if (tbl[t].mask[b]) sb.push_back(3'(b));
            tick();
            req_drv = 8'hff;
            chk("tbl_pend_e0", 32'(pending), 32'(tbl[t].mask));
            tick();
            chk("tbl_valid_e1", 32'(valid), 1);
            chk("tbl_first_code", 32'(code), 32'(tbl[t].exp_first));
            wait_drain("tbl", 40);
            chk("tbl_ovf", 32'(ovf), 0);
        end

        // Priority and stall: 6 held against a later 7, then 7 and 2
        ready = 1'b0;
        req_drv = ~8'h44;
        sb.push_back(3'd6); sb.push_back(3'd7); sb.push_back(3'd2);
        tick();
        req_drv = 8'hff;
        tick();
        chk("stall_code_e1", 32'(code), 6);
        tick();
        req_drv[7] = 1'b0;
        tick();
        req_drv = 8'hff;
        chk("stall_pend", 32'(pending), 32'hc4);
        tick();
        chk("stall_code_hold", 32'(code), 6);
        chk("stall_valid_hold", 32'(valid), 1);
        ready = 1'b1;
        wait_drain("stall", 40);

        // Overflow on bit 3
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_drv[3] = 1'b0;
            tick();
            req_drv = 8'hff;
            tick();
        end
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_pend", 32'(pending), 32'h08);
        chk("ovf_code", 32'(code), 3);
        sb.push_back(3'd3);
        ready = 1'b1;
        tick();
        chk("ovf_pend_after", 32'(pending), 0);
        chk("ovf_sticky", 32'(ovf), 1);
        wait_drain("ovf", 10);
        chk("ovf_sticky_late", 32'(ovf), 1);
        do_reset();
        tick();

        // Coincident set and clear on bit 4
        ready = 1'b0;
        req_drv[4] = 1'b0;
        tick();
        req_drv = 8'hff;
        tick();
        chk("coin_code", 32'(code), 4);
        req_drv[4] = 1'b0;
        ready = 1'b1;
        sb.push_back(3'd4); sb.push_back(3'd4);
        tick();
        req_drv = 8'hff;
        chk("coin_pend", 32'(pending), 32'h10);
        chk("coin_valid", 32'(valid), 0);
        tick();
        chk("coin_reoffer", 32'(valid), 1);
        chk("coin_recode", 32'(code), 4);
        wait_drain("coin", 10);
        chk("coin_ovf", 32'(ovf), 0);

        // Reset mid-offer, bit 0 held low across release
        ready = 1'b0;
        req_drv[1] = 1'b0;
        tick();
        req_drv = 8'hff;
        tick();
        chk("rmid_valid_pre", 32'(valid), 1);
        chk("rmid_code_pre", 32'(code), 1);
        req_drv[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("rmid_valid", 32'(valid), 0);
        chk("rmid_code", 32'(code), 0);
        chk("rmid_pending", 32'(pending), 0);
        chk("rmid_ovf", 32'(ovf), 0);
        tick();
        tick();
        rst = 1'b0;
        ready = 1'b1;
        sb.push_back(3'd0);
        tick();
        chk("rmid_pend_e0", 32'(pending), 32'h01);
        tick();
        chk("rmid_valid_e1", 32'(valid), 1);
        chk("rmid_code_e1", 32'(code), 0);
        wait_drain("rmid", 10);
        tick(); tick(); tick();
        chk("rmid_held_once", 32'(pending), 0);
        req_drv = 8'hff;
        tick();

        // Loopback through a 3-to-8 active-low decoder
        lb_mode = 1'b1;
        ready = 1'b1;
        for (int it = 0; it < 30; it++) begin
            dec_in = 3'($urandom_range(0, 7));
            sb.push_back(dec_in);
            dec_en = 1'b1;
            tick();
            dec_en = 1'b0;
            wait_drain("loop", 10);
            chk("loop_ok", 32'(lb_ok), 1);
        end
        chk("loop_ovf", 32'(ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_priority_encoder.md
REQ_PRIORITY_ENCODER -- requirements
Module: req_priority_encoder

Interface
REQ-001 Parameter N, default 8, number of request lines.
REQ-002 Parameter W, default 3, code width, SHALL equal clog2(N).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_n  input  N  active-low request lines, synchronous to clk; a 1->0 transition is one request event.
REQ-006 code  output  W  binary index of the offered request, registered.
REQ-007 valid  output  1  code is offered, registered.
REQ-008 ready  input  1  consumer accepts code; handshake completes on an edge where valid && ready.
REQ-009 pending  output  N  registered vector of captured, unserved requests.
REQ-010 ovf  output  1  sticky flag: a request event was lost.

Function
REQ-011 A 1->0 transition SHALL be detected per bit as prev[i] && !req_n[i], where prev is req_n registered every edge.
REQ-012 A detected event on bit i SHALL set pending[i] at that same edge.
REQ-013 A held-low req_n bit SHALL produce exactly one event.
REQ-014 FSM states: IDLE (valid=0) and OFFER (valid=1).
REQ-015 In IDLE with pending != 0, the next edge SHALL enter OFFER and load code with the highest set pending index (N-1 highest priority).
REQ-016 In IDLE with pending == 0, the FSM SHALL stay in IDLE.
REQ-017 In OFFER, code and valid SHALL hold stable until the handshake, even if higher-priority bits become pending.
REQ-018 At the handshake edge, pending[code] SHALL clear and the FSM SHALL return to IDLE.
REQ-019 After every handshake, valid SHALL be 0 for at least one cycle; peak throughput is one code per 2 cycles.
REQ-020 Latency: a falling edge sampled at edge E0 sets pending at E0; valid SHALL rise at E1.
REQ-021 If a new event on bit code coincides with its handshake, pending[code] SHALL remain set, set overriding clear.
REQ-022 An event on a bit whose pending is already 1, and not being cleared at that edge, SHALL be dropped and SHALL set ovf.
REQ-023 ovf SHALL clear only on reset.
REQ-024 Events on different bits at the same edge SHALL all be captured.
REQ-025 ready while in IDLE SHALL have no effect.

Reset
REQ-026 While rst is asserted: prev = all ones, pending = 0, code = 0, valid = 0, ovf = 0, state = IDLE.
REQ-027 Reset during OFFER SHALL discard the offered code immediately, without waiting for a clock edge.
REQ-028 req_n held low across reset release SHALL produce an event on the first edge after release.

Structure
REQ-029 A shared package SHALL hold the N and W defaults and the FSM state enum {IDLE, OFFER}.
REQ-030 The combinational highest-index selection SHALL be a sub-module prio_enc, with inputs vec[N-1:0] and outputs idx[W-1:0] and any.
REQ-031 All outputs SHALL be driven directly from flops.

Verification
REQ-032 Single request: pulse req_n[5] low for 1 cycle with ready=1 -> valid high one cycle later with code=5; pending=0 after the handshake; ovf=0.
REQ-033 Priority and stall: events on bits 2 and 6 at the same edge, ready=0 for 4 cycles, event on bit 7 during the stall -> code stays 6 until ready; then codes 7 and 2 follow, each separated by a valid=0 bubble.
REQ-034 Overflow: two events on bit 3 while it is pending and ready=0 -> ovf=1 and pending=8'h08; after one handshake pending=0 and ovf stays 1.
REQ-035 Coincident set/clear: event on bit 4 at the same edge as the handshake of code 4 -> pending[4] stays 1 and code 4 is offered again; ovf=0.
REQ-036 Reset mid-offer: assert rst while valid=1 with code=1 -> valid, pending, code and ovf go to 0 immediately; req_n[0] held low through release -> code 0 is offered after release.
REQ-037 Loopback: drive req_n from a 3-to-8 active-low decoder fed with random values -> every code equals the decoder input; the bench asserts an OK comparison signal each transfer.
